// File: rtl/qsfp_mgmt_pkg.sv
// Shared types and constants for the QSFP28 management controller.
// Used by qsfp_mgmt_port and qsfp_mgmt_ctrl (optional debounce: QSFP_MGMT_DEBOUNCE_EN).
package qsfp_mgmt_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    ABSENT = 2'd0,
    RESET  = 2'd1,
    INIT   = 2'd2,
    READY  = 2'd3
  } portState_e;

  // Width of a down-counter that must hold (largest cycle count - 1) without wrapping.
  function automatic int cntWidth(input int a, input int b);
    int largest;
    largest = (a > b) ? a : b;
    return (largest > 1) ? $clog2(largest) : 1;
  endfunction

endpackage

// File: rtl/qsfp_mgmt_port.sv
// One QSFP28 cage: input sync, optional modprsl debounce (QSFP_MGMT_DEBOUNCE_EN),
// bring-up FSM ABSENT -> RESET -> INIT -> READY, and the interrupt latch.
module qsfp_mgmt_port
  import qsfp_mgmt_pkg::*;
#(
  parameter int RESET_CYCLES    = 2500,
  parameter int INIT_CYCLES     = 500000000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic modprsl_i,
  input  logic intl_i,
  input  logic cfgLpmode_i,
  input  logic swResetReq_i,
  input  logic intClear_i,
  output logic resetl_o,
  output logic lpmode_o,
  output logic present_o,
  output logic ready_o,
  output logic intLatched_o
);

  localparam int CntW = cntWidth(RESET_CYCLES, INIT_CYCLES);
  localparam logic [CntW-1:0] ResetLoad = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] InitLoad  = CntW'(INIT_CYCLES - 1);

  // Sync flops hold active-high "present"/"interrupt" so a cleared chain reads as idle.
  logic [1:0] prsSync_q;
  logic [1:0] intSync_q;
  logic       prsValid;
  logic       intActive;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prsSync_q <= '0;
      intSync_q <= '0;
    end else begin
      prsSync_q <= {prsSync_q[0], ~modprsl_i};
      intSync_q <= {intSync_q[0], ~intl_i};
    end
  end

  assign intActive = intSync_q[1];

`ifdef QSFP_MGMT_DEBOUNCE_EN
  localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           prsStable_q;
  logic [DbW-1:0] dbCnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prsStable_q <= 1'b0;
      dbCnt_q     <= '0;
    end else if (prsSync_q[1] == prsStable_q) begin
      dbCnt_q <= '0;
    end else if (dbCnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
      prsStable_q <= prsSync_q[1];
      dbCnt_q     <= '0;
    end else begin
      dbCnt_q <= dbCnt_q + DbW'(1);
    end
  end

  assign prsValid = prsStable_q;
`else
  logic unusedDebounce;
  assign unusedDebounce = (DEBOUNCE_CYCLES > 0);
  assign prsValid       = prsSync_q[1];
`endif

  portState_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ABSENT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Presence loss beats sw reset, which beats counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!prsValid) begin
      state_d = ABSENT;
      cnt_d   = '0;
    end else if (state_q == ABSENT || swResetReq_i) begin
      state_d = RESET;
      cnt_d   = ResetLoad;
    end else begin
      case (state_q)
        RESET: begin
          if (cnt_q == '0) begin
            state_d = INIT;
            cnt_d   = InitLoad;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        INIT: begin
          if (cnt_q == '0) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  logic resetl_q, lpmode_q, present_q, ready_q, intLatched_q;
  logic resetl_d, lpmode_d, present_d, ready_d, intLatched_d;

  always_comb begin
    resetl_d  = (state_d == INIT) || (state_d == READY);
    present_d = (state_d != ABSENT);
    ready_d   = (state_d == READY);
    lpmode_d  = cfgLpmode_i || (state_d != READY);
    if (state_d == ABSENT || state_d == RESET) begin
      intLatched_d = 1'b0;
    end else if (state_q == READY && intActive) begin
      intLatched_d = 1'b1;
    end else if (intClear_i) begin
      intLatched_d = 1'b0;
    end else begin
      intLatched_d = intLatched_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resetl_q     <= 1'b0;
      lpmode_q     <= 1'b1;
      present_q    <= 1'b0;
      ready_q      <= 1'b0;
      intLatched_q <= 1'b0;
    end else begin
      resetl_q     <= resetl_d;
      lpmode_q     <= lpmode_d;
      present_q    <= present_d;
      ready_q      <= ready_d;
      intLatched_q <= intLatched_d;
    end
  end

  assign resetl_o     = resetl_q;
  assign lpmode_o     = lpmode_q;
  assign present_o    = present_q;
  assign ready_o      = ready_q;
  assign intLatched_o = intLatched_q;

endmodule

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP28 cage manager: NUM_PORTS bring-up channels plus one-hot-low I2C modsell decode.
// Define QSFP_MGMT_DEBOUNCE_EN to debounce modprsl for DEBOUNCE_CYCLES.
module qsfp_mgmt_ctrl
  import qsfp_mgmt_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int RESET_CYCLES    = 2500,
  parameter int INIT_CYCLES     = 500000000,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int SelW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_250mhz,
  input  logic                 rst_250mhz_n,
  input  logic [NUM_PORTS-1:0] qsfp_modprsl,
  input  logic [NUM_PORTS-1:0] qsfp_intl,
  output logic [NUM_PORTS-1:0] qsfp_resetl,
  output logic [NUM_PORTS-1:0] qsfp_lpmode,
  output logic [NUM_PORTS-1:0] qsfp_modsell,
  input  logic [NUM_PORTS-1:0] cfg_lpmode,
  input  logic [NUM_PORTS-1:0] sw_reset_req,
  input  logic [SelW-1:0]      i2c_sel,
  input  logic                 i2c_sel_en,
  input  logic [NUM_PORTS-1:0] int_clear,
  output logic [NUM_PORTS-1:0] present,
  output logic [NUM_PORTS-1:0] ready,
  output logic [NUM_PORTS-1:0] int_latched
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : gPort
    qsfp_mgmt_port #(
      .RESET_CYCLES   (RESET_CYCLES),
      .INIT_CYCLES    (INIT_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uPort (
      .clk_i       (clk_250mhz),
      .rst_ni      (rst_250mhz_n),
      .modprsl_i   (qsfp_modprsl[i]),
      .intl_i      (qsfp_intl[i]),
      .cfgLpmode_i (cfg_lpmode[i]),
      .swResetReq_i(sw_reset_req[i]),
      .intClear_i  (int_clear[i]),
      .resetl_o    (qsfp_resetl[i]),
      .lpmode_o    (qsfp_lpmode[i]),
      .present_o   (present[i]),
      .ready_o     (ready[i]),
      .intLatched_o(int_latched[i])
    );
  end

  logic [NUM_PORTS-1:0] modsell_q, modsell_d;

  // A single index compare guarantees at most one low bit; out-of-range indices match nothing.
  always_comb begin
    modsell_d = '1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i2c_sel_en && ready[i] && (int'(i2c_sel) == i)) begin
        modsell_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_250mhz) begin
    if (!rst_250mhz_n) begin
      modsell_q <= '1;
    end else begin
      modsell_q <= modsell_d;
    end
  end

  assign qsfp_modsell = modsell_q;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Self-checking bench for qsfp_mgmt_ctrl: directed scenarios then randomized traffic,
// all compared against an elapsed-time reference model (honours QSFP_MGMT_DEBOUNCE_EN).
module tb_qsfp_mgmt_ctrl;

  localparam int NP  = 2;
  localparam int RC  = 4;
  localparam int IC  = 8;
  localparam int DC  = 16;
  localparam int SEQ = RC + IC;

  logic          clk = 1'b0;
  logic          rstN;
  logic [NP-1:0] modprsl, intl, cfgLpmode, swReset, intClear;
  logic [0:0]    i2cSel;
  logic          i2cSelEn;
  logic [NP-1:0] resetl, lpmode, modsell, present, ready, intLatched;

  qsfp_mgmt_ctrl #(
    .NUM_PORTS      (NP),
    .RESET_CYCLES   (RC),
    .INIT_CYCLES    (IC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_250mhz  (clk),
    .rst_250mhz_n(rstN),
    .qsfp_modprsl(modprsl),
    .qsfp_intl   (intl),
    .qsfp_resetl (resetl),
    .qsfp_lpmode (lpmode),
    .qsfp_modsell(modsell),
    .cfg_lpmode  (cfgLpmode),
    .sw_reset_req(swReset),
    .i2c_sel     (i2cSel),
    .i2c_sel_en  (i2cSelEn),
    .int_clear   (intClear),
    .present     (present),
    .ready       (ready),
    .int_latched (intLatched)
  );

  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model: age = cycles since the bring-up sequence (re)started, -1 when absent.
  int            age     [NP];
  bit            prsPipe [NP][2];
  bit            intPipe [NP][2];
`ifdef QSFP_MGMT_DEBOUNCE_EN
  bit            debPrs  [NP];
  int            debRun  [NP];
`endif
  logic [NP-1:0] expPresent, expReady, expResetl, expLpmode, expInt, expModsell;

  task automatic checkOutput(input string tag, input logic [NP-1:0] observed,
                             input logic [NP-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < NP; p++) begin
      age[p]        = -1;
      prsPipe[p][0] = 1'b0;
      prsPipe[p][1] = 1'b0;
      intPipe[p][0] = 1'b0;
      intPipe[p][1] = 1'b0;
`ifdef QSFP_MGMT_DEBOUNCE_EN
      debPrs[p] = 1'b0;
      debRun[p] = 0;
`endif
    end
    expPresent = '0;
    expReady   = '0;
    expResetl  = '0;
    expLpmode  = '1;
    expInt     = '0;
    expModsell = '1;
  endtask

  task automatic modelStep();
    logic [NP-1:0] prevReady;
    prevReady = expReady;
    for (int p = 0; p < NP; p++) begin
      bit seen, intSeen, fsmPrs;
      int prevAge;
      seen          = prsPipe[p][1];
      intSeen       = intPipe[p][1];
      prsPipe[p][1] = prsPipe[p][0];
      prsPipe[p][0] = !modprsl[p];
      intPipe[p][1] = intPipe[p][0];
      intPipe[p][0] = !intl[p];
`ifdef QSFP_MGMT_DEBOUNCE_EN
      fsmPrs = debPrs[p];
      if (seen == debPrs[p]) begin
        debRun[p] = 0;
      end else begin
        debRun[p]++;
        if (debRun[p] == DC) begin
          debPrs[p] = seen;
          debRun[p] = 0;
        end
      end
`else
      fsmPrs = seen;
`endif
      prevAge = age[p];
      if (!fsmPrs) age[p] = -1;
      else if (prevAge < 0 || swReset[p]) age[p] = 0;
      else if (prevAge < SEQ) age[p] = prevAge + 1;

      expPresent[p] = (age[p] >= 0);
      expResetl[p]  = (age[p] >= RC);
      expReady[p]   = (age[p] >= SEQ);
      expLpmode[p]  = cfgLpmode[p] || !expReady[p];
      if (age[p] < RC) expInt[p] = 1'b0;
      else if (prevAge >= SEQ && intSeen) expInt[p] = 1'b1;
      else if (intClear[p]) expInt[p] = 1'b0;
      expModsell[p] = !(i2cSelEn && (int'(i2cSel) == p) && prevReady[p]);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      if (!rstN) modelReset();
      else modelStep();
      #1;
      checkOutput("present", present, expPresent);
      checkOutput("ready", ready, expReady);
      checkOutput("resetl", resetl, expResetl);
      checkOutput("lpmode", lpmode, expLpmode);
      checkOutput("intLatched", intLatched, expInt);
      checkOutput("modsell", modsell, expModsell);
      @(negedge clk);
    end
  endtask

  task automatic directedChecks();
    // Insertion timing on port 0
    modprsl[0] = 1'b0;
    applyStimulus(2);
    checkOutput("prsBefore3", NP'(present[0]), NP'(0));
    applyStimulus(1);
    checkOutput("prsAt3", NP'(present[0]), NP'(1));
    applyStimulus(3);
    checkOutput("resetlLow4", NP'(resetl[0]), NP'(0));
    applyStimulus(1);
    checkOutput("resetlHigh", NP'(resetl[0]), NP'(1));
    applyStimulus(7);
    checkOutput("readyEarly", NP'(ready[0]), NP'(0));
    applyStimulus(1);
    checkOutput("readyAt8", NP'(ready[0]), NP'(1));

    // Interrupt set wins over a simultaneous clear
    intl[0] = 1'b0;
    applyStimulus(1);
    intl[0] = 1'b1;
    applyStimulus(1);
    intClear[0] = 1'b1;
    applyStimulus(1);
    intClear[0] = 1'b0;
    applyStimulus(1);
    checkOutput("intSetWins", NP'(intLatched[0]), NP'(1));
    intClear[0] = 1'b1;
    applyStimulus(1);
    intClear[0] = 1'b0;
    checkOutput("intCleared", NP'(intLatched[0]), NP'(0));

    cfgLpmode[0] = 1'b1;
    applyStimulus(1);
    checkOutput("lpmodeCfg", NP'(lpmode[0]), NP'(1));
    cfgLpmode[0] = 1'b0;
    applyStimulus(1);
    checkOutput("lpmodeReady", NP'(lpmode[0]), NP'(0));

    // Port 1: sw reset while INIT counter reads 3
    modprsl[1] = 1'b0;
    applyStimulus(3 + RC + 4);
    swReset[1] = 1'b1;
    applyStimulus(1);
    swReset[1] = 1'b0;
    checkOutput("swRstLow", NP'(resetl[1]), NP'(0));
    applyStimulus(3);
    checkOutput("swRstLow4", NP'(resetl[1]), NP'(0));
    applyStimulus(1);
    checkOutput("swRstInit", NP'(resetl[1]), NP'(1));
    applyStimulus(IC - 1);
    checkOutput("swRstNotRdy", NP'(ready[1]), NP'(0));
    applyStimulus(1);
    checkOutput("swRstReady", NP'(ready[1]), NP'(1));

    // Alternating I2C select with both ports ready
    i2cSelEn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i2cSel = 1'(k % 2);
      applyStimulus(1);
      checkOutput("modsellAlt", modsell, (k % 2 == 0) ? NP'(2'b10) : NP'(2'b01));
    end
    i2cSelEn = 1'b0;

    // Removal of port 1 while READY with a latched interrupt
    intl[1] = 1'b0;
    applyStimulus(3);
    intl[1] = 1'b1;
    checkOutput("int1Set", NP'(intLatched[1]), NP'(1));
    modprsl[1] = 1'b1;
    applyStimulus(3);
    checkOutput("rmReady", NP'(ready[1]), NP'(0));
    checkOutput("rmPresent", NP'(present[1]), NP'(0));
    checkOutput("rmResetl", NP'(resetl[1]), NP'(0));
    checkOutput("rmInt", NP'(intLatched[1]), NP'(0));

    // Reset asserted while port 1 is in INIT
    modprsl[1] = 1'b0;
    applyStimulus(3 + RC + 2);
    rstN = 1'b0;
    applyStimulus(1);
    checkOutput("midRstResetl", resetl, NP'(0));
    checkOutput("midRstLpmode", lpmode, '1);
    checkOutput("midRstModsell", modsell, '1);
    checkOutput("midRstPresent", present, NP'(0));
    checkOutput("midRstReady", ready, NP'(0));
    checkOutput("midRstInt", intLatched, NP'(0));
    rstN = 1'b1;
    applyStimulus(20);
  endtask

  task automatic glitchChecks();
    modprsl[1] = 1'b0;
    applyStimulus(10);
    modprsl[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1);
      checkOutput("glitchPresent", NP'(present[1]), NP'(0));
    end
    modprsl[0] = 1'b0;
    applyStimulus(2 + DC + 1);
    checkOutput("debPresent", NP'(present[0]), NP'(1));
  endtask

  initial begin
    rstN      = 1'b0;
    modprsl   = '1;
    intl      = '1;
    cfgLpmode = '0;
    swReset   = '0;
    intClear  = '0;
    i2cSel    = '0;
    i2cSelEn  = 1'b0;
    modelReset();
    @(negedge clk);
    applyStimulus(3);
    checkOutput("rstResetl", resetl, NP'(0));
    checkOutput("rstLpmode", lpmode, '1);
    checkOutput("rstModsell", modsell, '1);
    checkOutput("rstPresent", present, NP'(0));
    checkOutput("rstReady", ready, NP'(0));
    checkOutput("rstInt", intLatched, NP'(0));
    rstN = 1'b1;
    applyStimulus(2);

`ifdef QSFP_MGMT_DEBOUNCE_EN
    glitchChecks();
`else
    directedChecks();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstN = ($urandom_range(0, 399) != 0);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 79) == 0) modprsl[p] = ~modprsl[p];
        if ($urandom_range(0, 15) == 0) cfgLpmode[p] = ~cfgLpmode[p];
        intl[p]     = ($urandom_range(0, 7) != 0);
        swReset[p]  = ($urandom_range(0, 39) == 0);
        intClear[p] = ($urandom_range(0, 5) == 0);
      end
      i2cSel   = 1'($urandom_range(0, 1));
      i2cSelEn = ($urandom_range(0, 3) != 0);
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
